// File: rtl/tl45_wb_uart.sv
// Generic circular FIFO with pointers one bit wider than the index, full/empty by pointer compare.
// Latency: a pushed word is visible at pop_dat the cycle after the push; pop_dat is the head, read combinationally.
// Backpressure: the caller must not push when full unless it pops in the same cycle; the head is read before the write lands.
module tl45_wb_uart_fifo #(
    parameter int W  = 8,
    parameter int LG = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [LG:0]   count
);
    logic [W-1:0] mem [2**LG];
    logic [LG:0]  wr_ptr;
    logic [LG:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + (LG+1)'(1);
            if (pop_rdy)  rd_ptr <= rd_ptr + (LG+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr[LG-1:0]] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr[LG-1:0]];
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[LG] != rd_ptr[LG]) && (wr_ptr[LG-1:0] == rd_ptr[LG-1:0]);
endmodule

// Wishbone-mapped 8N1 UART: TX FIFO + serializer, RX deserializer with one-byte holding register.
// Latency: ack and read data one cycle after each request; a byte pushed to an idle TX starts its start bit 2 cycles later.
// Backpressure: never stalls; TX writes to a full FIFO are dropped and flagged, unread RX bytes are overwritten and flagged.
module tl45_wb_uart #(
    parameter int CLKS_PER_BAUD = 434,
    parameter int TXFIFO_LG     = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    input  logic        i_uart_rx,
    output logic        o_uart_tx
);
    localparam logic [15:0] BAUD_M1 = 16'(CLKS_PER_BAUD - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BAUD / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    typedef struct packed {
        logic framerr;
        logic rx_ovr;
        logic tx_drop;
        logic rx_vld;
        logic tx_full;
        logic tx_idle;
    } status_t;

    // Bus decode
    logic req, wr_en, rd_en, push_req, rx_rd, stat_wr;
    assign req      = i_wb_cyc & i_wb_stb;
    assign wr_en    = req & i_wb_we & i_wb_sel[0];
    assign rd_en    = req & ~i_wb_we;
    assign push_req = wr_en & (i_wb_addr == 2'd0);
    assign stat_wr  = wr_en & (i_wb_addr == 2'd2);
    assign rx_rd    = rd_en & (i_wb_addr == 2'd1);

    wire unused_bits = &{1'b0, i_wb_data[31:8], i_wb_sel[3:1]};

    // TX FIFO
    logic                 fifo_full, fifo_empty, tx_pop, fifo_push, drop;
    logic [7:0]           fifo_dat;
    logic [TXFIFO_LG:0]   fifo_cnt;

    assign fifo_push = push_req & (~fifo_full | tx_pop);
    assign drop      = push_req & fifo_full & ~tx_pop;

    tl45_wb_uart_fifo #(.W(8), .LG(TXFIFO_LG)) u_txq (
        .clk      (i_clk),
        .rst_n    (i_reset),
        .push_vld (fifo_push),
        .push_dat (i_wb_data[7:0]),
        .pop_rdy  (tx_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    // TX serializer
    uart_state_t tx_state, tx_state_nxt;
    logic [15:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]  tx_bit, tx_bit_nxt;
    logic [7:0]  tx_shift, tx_shift_nxt;
    logic        tx_line, tx_line_nxt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            tx_line  <= tx_line_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_line_nxt  = tx_line;
        tx_pop       = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    tx_pop       = 1'b1;
                    tx_state_nxt = ST_START;
                    tx_cnt_nxt   = BAUD_M1;
                    tx_shift_nxt = fifo_dat;
                    tx_line_nxt  = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt == 16'd0) begin
                    tx_state_nxt = ST_DATA;
                    tx_cnt_nxt   = BAUD_M1;
                    tx_bit_nxt   = 3'd0;
                    tx_line_nxt  = tx_shift[0];
                end else begin
                    tx_cnt_nxt = tx_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt == 16'd0) begin
                    tx_cnt_nxt = BAUD_M1;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = ST_STOP;
                        tx_line_nxt  = 1'b1;
                    end else begin
                        tx_bit_nxt   = tx_bit + 3'd1;
                        tx_shift_nxt = {1'b0, tx_shift[7:1]};
                        tx_line_nxt  = tx_shift[1];
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (tx_cnt == 16'd0) begin
                    // Chain straight into the next start bit so bursts have no idle gap
                    if (!fifo_empty) begin
                        tx_pop       = 1'b1;
                        tx_state_nxt = ST_START;
                        tx_cnt_nxt   = BAUD_M1;
                        tx_shift_nxt = fifo_dat;
                        tx_line_nxt  = 1'b0;
                    end else begin
                        tx_state_nxt = ST_IDLE;
                        tx_line_nxt  = 1'b1;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - 16'd1;
                end
            end
        endcase
    end

    assign o_uart_tx = tx_line;

    // RX synchronizer and deserializer
    logic [1:0]  rx_sync;
    logic        rx_s;
    uart_state_t rx_state, rx_state_nxt;
    logic [15:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]  rx_bit, rx_bit_nxt;
    logic [7:0]  rx_shift, rx_shift_nxt;
    logic        rx_done, rx_ferr;

    assign rx_s = rx_sync[1];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_sync  <= 2'b11;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], i_uart_rx};
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_done      = 1'b0;
        rx_ferr      = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (!rx_s) begin
                    rx_state_nxt = ST_START;
                    rx_cnt_nxt   = HALF_M1;
                end
            end
            ST_START: begin
                if (rx_cnt == 16'd0) begin
                    // Line back high at mid start bit: treat as noise
                    if (rx_s) begin
                        rx_state_nxt = ST_IDLE;
                    end else begin
                        rx_state_nxt = ST_DATA;
                        rx_cnt_nxt   = BAUD_M1;
                        rx_bit_nxt   = 3'd0;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt == 16'd0) begin
                    rx_shift_nxt = {rx_s, rx_shift[7:1]};
                    rx_cnt_nxt   = BAUD_M1;
                    if (rx_bit == 3'd7) rx_state_nxt = ST_STOP;
                    else                rx_bit_nxt   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_nxt = rx_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (rx_cnt == 16'd0) begin
                    rx_state_nxt = ST_IDLE;
                    rx_done      = rx_s;
                    rx_ferr      = ~rx_s;
                end else begin
                    rx_cnt_nxt = rx_cnt - 16'd1;
                end
            end
        endcase
    end

    // Holding register and sticky flags; a set in the same cycle as a clear wins
    logic [7:0] rx_byte;
    logic       rx_vld, rx_ovr, tx_drop, framerr;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_byte <= '0;
            rx_vld  <= 1'b0;
            rx_ovr  <= 1'b0;
            tx_drop <= 1'b0;
            framerr <= 1'b0;
        end else begin
            if (rx_done) rx_byte <= rx_shift;
            rx_vld  <= rx_done | (rx_vld & ~rx_rd);
            rx_ovr  <= (rx_ovr  & ~(stat_wr & i_wb_data[4])) | (rx_done & rx_vld & ~rx_rd);
            tx_drop <= (tx_drop & ~(stat_wr & i_wb_data[3])) | drop;
            framerr <= (framerr & ~(stat_wr & i_wb_data[5])) | rx_ferr;
        end
    end

    // Read mux and bus response
    status_t     status;
    logic [31:0] rd_mux;

    always_comb begin
        status.framerr = framerr;
        status.rx_ovr  = rx_ovr;
        status.tx_drop = tx_drop;
        status.rx_vld  = rx_vld;
        status.tx_full = fifo_full;
        status.tx_idle = fifo_empty & (tx_state == ST_IDLE);
        rd_mux = '0;
        case (i_wb_addr)
            2'd1:    rd_mux = {23'd0, rx_vld, rx_byte};
            2'd2:    rd_mux = {26'd0, status};
            2'd3:    rd_mux = {{(31-TXFIFO_LG){1'b0}}, fifo_cnt};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack  <= req;
            o_wb_data <= rd_en ? rd_mux : 32'd0;
        end
    end

    assign o_wb_stall = 1'b0;
endmodule

// File: tb/tb_tl45_wb_uart.sv
// Bench for tl45_wb_uart at 4 clocks/bit with a 4-entry TX FIFO: register table, bit-timing and RX corner
// sequences, then randomized TX bursts and RX frames against a byte-level model and a serial line decoder.
module tb_tl45_wb_uart;
    localparam int CPB = 4;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [1:0]  i_wb_addr = 2'd0;
    logic [31:0] i_wb_data = 32'd0;
    logic [3:0]  i_wb_sel = 4'd0;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;
    logic        i_uart_rx = 1'b1;
    logic        o_uart_tx;

    tl45_wb_uart #(.CLKS_PER_BAUD(CPB), .TXFIFO_LG(2)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .i_wb_sel   (i_wb_sel),
        .o_wb_ack   (o_wb_ack),
        .o_wb_stall (o_wb_stall),
        .o_wb_data  (o_wb_data),
        .i_uart_rx  (i_uart_rx),
        .o_uart_tx  (o_uart_tx)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [7:0]  exp_tx[$];
    logic [7:0]  seen_tx[$];
    logic [7:0]  bbuf[8];
    logic [7:0]  last_rx;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic ack, output logic [31:0] q);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
        i_wb_addr = a; i_wb_data = d; i_wb_sel = s;
        tick();
        ack = o_wb_ack;
        q = o_wb_data;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    endtask

    task automatic rd_raw(input logic [1:0] a, input string nm, output logic [31:0] q);
        logic ack;
        wb(1'b0, a, 32'd0, 4'hF, ack, q);
        chk({nm, " ack"}, 32'(ack), 32'd1);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        logic [31:0] q;
        rd_raw(a, nm, q);
        chk(nm, q, e);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input string nm);
        logic ack;
        logic [31:0] q;
        wb(1'b1, a, d, 4'h1, ack, q);
        chk({nm, " ack"}, 32'(ack), 32'd1);
    endtask

    task automatic burst(input int n);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
        i_wb_addr = 2'd0; i_wb_sel = 4'h1;
        for (int i = 0; i < n; i++) begin
            i_wb_data = {24'd0, bbuf[i]};
            tick();
            chk($sformatf("burst ack%0d", i), 32'(o_wb_ack), 32'd1);
        end
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        tick();
        chk("burst ack drop", 32'(o_wb_ack), 32'd0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        i_uart_rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            i_uart_rx = b[i];
            repeat (CPB) tick();
        end
        i_uart_rx = stop_bit;
        repeat (CPB) tick();
        i_uart_rx = 1'b1;
        repeat (6) tick();
    endtask

    task automatic drain_tx();
        int t;
        logic [7:0] s, e;
        t = 0;
        while (seen_tx.size() < exp_tx.size() && t < 3000) begin
            tick();
            t++;
        end
        if (seen_tx.size() < exp_tx.size()) begin
            n_vec++; n_miss++;
            $display("FAIL tx drain timeout: got %0d bytes, expected %0d", seen_tx.size(), exp_tx.size());
        end
        while (exp_tx.size() > 0 && seen_tx.size() > 0) begin
            s = seen_tx.pop_front();
            e = exp_tx.pop_front();
            chk("tx byte", 32'(s), 32'(e));
        end
        if (seen_tx.size() != 0) begin
            n_vec++; n_miss++;
            $display("FAIL tx extra bytes: got %0d extra, expected 0", seen_tx.size());
        end
        exp_tx.delete();
        seen_tx.delete();
        repeat (8) tick();
    endtask

    // Serial line decoder: finds a start bit, samples each bit at its middle
    initial begin : tx_mon
        logic [7:0] b;
        b = 8'd0;
        forever begin
            tick();
            if (o_uart_tx === 1'b0) begin
                repeat (CPB / 2) tick();
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) tick();
                    b[i] = o_uart_tx;
                end
                repeat (CPB) tick();
                if (o_uart_tx === 1'b1) seen_tx.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        tbl[12];
        logic [9:0]  fr;
        logic [31:0] q;
        logic [7:0]  rb;
        logic        ack;
        bit          bad;
        int          n;

        tbl[0]  = '{1'b0, 2'd0, 32'd0,   4'hF, 32'h000};
        tbl[1]  = '{1'b0, 2'd1, 32'd0,   4'hF, 32'h000};
        tbl[2]  = '{1'b0, 2'd2, 32'd0,   4'hF, 32'h001};
        tbl[3]  = '{1'b0, 2'd3, 32'd0,   4'hF, 32'h000};
        tbl[4]  = '{1'b1, 2'd0, 32'hAB,  4'hE, 32'h000};
        tbl[5]  = '{1'b0, 2'd3, 32'd0,   4'hF, 32'h000};
        tbl[6]  = '{1'b1, 2'd1, 32'hFF,  4'h1, 32'h000};
        tbl[7]  = '{1'b0, 2'd1, 32'd0,   4'hF, 32'h000};
        tbl[8]  = '{1'b1, 2'd2, 32'h38,  4'h1, 32'h000};
        tbl[9]  = '{1'b0, 2'd2, 32'd0,   4'hF, 32'h001};
        tbl[10] = '{1'b1, 2'd3, 32'h5,   4'h1, 32'h000};
        tbl[11] = '{1'b0, 2'd3, 32'd0,   4'hF, 32'h000};

        // Reset state
        #1 i_reset = 1'b0;
        #2;
        chk("reset ack", 32'(o_wb_ack), 32'd0);
        chk("reset data", o_wb_data, 32'd0);
        chk("reset tx", 32'(o_uart_tx), 32'd1);
        chk("reset stall", 32'(o_wb_stall), 32'd0);
        repeat (3) tick();
        i_reset = 1'b1;
        tick();

        // Register table
        for (int i = 0; i < 12; i++) begin
            wb(tbl[i].we, tbl[i].addr, tbl[i].wdat, tbl[i].sel, ack, q);
            chk($sformatf("tbl%0d ack", i), 32'(ack), 32'd1);
            if (!tbl[i].we) chk($sformatf("tbl%0d data", i), q, tbl[i].exp);
        end

        // TX bit timing for 0x55
        wr(2'd0, 32'h55, "tx55 wr");
        exp_tx.push_back(8'h55);
        chk("tx55 pre", 32'(o_uart_tx), 32'd1);
        fr = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < CPB; k++) begin
                tick();
                chk($sformatf("tx55 bit%0d.%0d", i, k), 32'(o_uart_tx), 32'(fr[i]));
            end
        end
        tick();
        rd(2'd2, 32'h01, "tx55 status");
        drain_tx();

        // FIFO overflow: 6 back-to-back writes into a 4-deep FIFO
        for (int i = 0; i < 6; i++) bbuf[i] = 8'(8'h31 + i);
        for (int i = 0; i < 5; i++) exp_tx.push_back(bbuf[i]);
        burst(6);
        rd(2'd3, 32'd4, "ovf txcount");
        rd(2'd2, 32'h0A, "ovf status");
        wr(2'd2, 32'h08, "ovf clr");
        rd(2'd2, 32'h02, "ovf status clr");
        drain_tx();

        // RX single frame
        send_rx(8'hA3, 1'b1);
        rd(2'd2, 32'h05, "rxA3 status");
        rd(2'd1, 32'h1A3, "rxA3 read1");
        rd(2'd1, 32'h0A3, "rxA3 read2");
        rd(2'd2, 32'h01, "rxA3 status2");

        // RX overrun, then framing error
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd(2'd2, 32'h15, "ovr status");
        rd(2'd1, 32'h122, "ovr rxdata");
        send_rx(8'h5A, 1'b0);
        rd(2'd2, 32'h31, "ferr status");
        wr(2'd2, 32'h38, "ferr clr");
        rd(2'd2, 32'h01, "ferr status clr");
        last_rx = 8'h22;

        // Short glitch must not start a frame
        i_uart_rx = 1'b0;
        repeat (2) tick();
        i_uart_rx = 1'b1;
        repeat (20) tick();
        rd(2'd2, 32'h01, "glitch status");
        rd(2'd1, 32'h022, "glitch rxhold");

        // Randomized TX bursts overlapped with RX frames
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                bbuf[i] = 8'($urandom);
                exp_tx.push_back(bbuf[i]);
            end
            burst(n);
            rb = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_rx(rb, !bad);
            rd_raw(2'd2, "rnd status", q);
            if (!bad) begin
                chk("rnd flags", 32'(q[5:2]), 32'h1);
                rd(2'd1, {23'd0, 1'b1, rb}, "rnd rxdata");
                last_rx = rb;
            end else begin
                chk("rnd flags ferr", 32'(q[5:2]), 32'h8);
                wr(2'd2, 32'h20, "rnd ferr clr");
                rd(2'd1, {23'd0, 1'b0, last_rx}, "rnd rxhold");
            end
            drain_tx();
        end

        // Reset in the middle of a byte
        bbuf[0] = 8'h00; bbuf[1] = 8'h00; bbuf[2] = 8'h00;
        burst(3);
        repeat (8) tick();
        chk("rst mid tx low", 32'(o_uart_tx), 32'd0);
        wb(1'b0, 2'd2, 32'd0, 4'hF, ack, q);
        chk("rst pre ack", 32'(ack), 32'd1);
        i_reset = 1'b0;
        #1;
        chk("rst tx", 32'(o_uart_tx), 32'd1);
        chk("rst ack", 32'(o_wb_ack), 32'd0);
        chk("rst data", o_wb_data, 32'd0);
        repeat (3) tick();
        i_reset = 1'b1;
        tick();
        rd(2'd3, 32'd0, "rst txcount");
        rd(2'd2, 32'h01, "rst status");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
